// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transmitter.
// Frame geometry is fixed at 2 x 32-bit slots carrying 16-bit samples.
package i2s_pkg;

    localparam int SAMPLE_BITS    = 16;
    localparam int SLOT_BITS      = 32;
    localparam int FRAME_BITS     = 64;
    localparam int POS_BITS       = 6;
    localparam int DATA_START_POS = 33;
    localparam int DATA_END_POS   = 48;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

endpackage

// File: rtl/i2s_clkgen.sv
// Serial clock divider: toggles sck every CLK_DIV clks while run is high.
// rise/fall mark the clk on whose edge sck changes.
module i2s_clkgen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] TC = 8'(CLK_DIV - 1);

    logic [7:0] div;
    logic       tc;

    assign tc   = run && (div == TC);
    assign rise = tc & ~sck;
    assign fall = tc & sck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            sck <= 1'b0;
        end else if (!run) begin
            div <= '0;
            sck <= 1'b0;
        end else if (tc) begin
            div <= '0;
            sck <= ~sck;
        end else begin
            div <= div + 8'd1;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one 16-bit word per frame, sent in the right slot
// with the one-bit I2S delay; left slot and padding are zero.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [SAMPLE_BITS-1:0] din,
    input  logic                   din_vld,
    output logic                   din_rdy,
    output logic                   sck,
    output logic                   ws,
    output logic                   sd,
    output logic                   underrun
);

    localparam logic [POS_BITS-1:0] LOAD_POS  = POS_BITS'(SLOT_BITS);
    localparam logic [POS_BITS-1:0] FIRST_POS = POS_BITS'(DATA_START_POS);
    localparam logic [POS_BITS-1:0] LAST_POS  = POS_BITS'(DATA_END_POS);
    localparam logic [POS_BITS-1:0] END_POS   = POS_BITS'(FRAME_BITS - 1);

    state_t                 state;
    logic [POS_BITS-1:0]    pos;
    logic [POS_BITS-1:0]    pos_n;
    logic [SAMPLE_BITS-1:0] hold;
    logic [SAMPLE_BITS-1:0] shreg;
    logic                   hold_full;
    logic                   accept;
    logic                   in_data;
    logic                   run;
    logic                   fall;
    logic                   rise_unused;

    assign run     = (state == RUN);
    assign accept  = din_vld & ~hold_full;
    assign pos_n   = pos + 6'd1;
    assign in_data = (pos_n >= FIRST_POS) && (pos_n <= LAST_POS);
    assign din_rdy = ~hold_full;

    i2s_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (run),
        .sck  (sck),
        .rise (rise_unused),
        .fall (fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pos       <= '0;
            ws        <= 1'b0;
            sd        <= 1'b0;
            hold      <= '0;
            hold_full <= 1'b0;
            shreg     <= '0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (accept) begin
                hold      <= din;
                hold_full <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    pos <= '0;
                    ws  <= 1'b0;
                    sd  <= 1'b0;
                    if (en) state <= RUN;
                end
                RUN: begin
                    if (fall) begin
                        // Stopping only at the frame wrap keeps frames whole
                        if (pos == END_POS && !en) begin
                            state <= IDLE;
                            pos   <= '0;
                            ws    <= 1'b0;
                            sd    <= 1'b0;
                        end else begin
                            pos <= pos_n;
                            ws  <= pos_n[POS_BITS-1];
                            sd  <= 1'b0;
                            if (pos_n == LOAD_POS) begin
                                if (hold_full) begin
                                    shreg     <= hold;
                                    hold_full <= 1'b0;
                                end else begin
                                    shreg    <= '0;
                                    underrun <= 1'b1;
                                end
                            end else if (in_data) begin
                                sd    <= shreg[SAMPLE_BITS-1];
                                shreg <= {shreg[SAMPLE_BITS-2:0], 1'b0};
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx with a 2-flop-sync receiver model and a
// queue of expected words per right slot.
module tb_i2s_tx;

    localparam int CLK_DIV    = 16;
    localparam int FRAME_CLKS = 64 * 2 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] din = '0;
    logic        din_vld = 1'b0;
    logic        din_rdy;
    logic        sck;
    logic        ws;
    logic        sd;
    logic        underrun;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    i2s_tx #(
        .CLK_DIV(CLK_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .din     (din),
        .din_vld (din_vld),
        .din_rdy (din_rdy),
        .sck     (sck),
        .ws      (ws),
        .sd      (sd),
        .underrun(underrun)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag, input int n);
        checks++;
        errors++;
        $error("FAIL %s: no event within %0d clks", tag, n);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return ws;
            1:       return sck;
            default: return underrun;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic val, input int max,
                            input string tag);
        int n;
        n = 0;
        while (sig(sel) !== val && n < max) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) timeout(tag, max);
    endtask

    task automatic falls(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            wait_for(1, 1'b1, 4 * CLK_DIV, "sck_hi");
            wait_for(1, 1'b0, 4 * CLK_DIV, "sck_lo");
        end
    endtask

    task automatic send(input logic [15:0] w);
        int n;
        n = 0;
        din     = w;
        din_vld = 1'b1;
        while (!din_rdy && n < 3 * FRAME_CLKS) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3 * FRAME_CLKS) timeout("send", n);
        @(posedge clk);
        exp_q.push_back(w);
        @(negedge clk);
        din_vld = 1'b0;
    endtask

    // Receiver: sync ws/sck, bit count zeroed on ws rise, sample on sck rise
    logic [2:0]  ws_s;
    logic [2:0]  sck_s;
    logic [15:0] rx_sh;
    int          rx_cnt;

    task automatic rx_word(input logic [15:0] got);
        logic [15:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
        check("rx_word", 32'(got), 32'(e));
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            ws_s   <= '0;
            sck_s  <= '0;
            rx_sh  <= '0;
            rx_cnt <= 99;
        end else begin
            ws_s  <= {ws_s[1:0], ws};
            sck_s <= {sck_s[1:0], sck};
            if (ws_s[1] && !ws_s[2]) begin
                rx_cnt <= 0;
            end else if (sck_s[1] && !sck_s[2]) begin
                if (rx_cnt >= 1 && rx_cnt <= 16) begin
                    rx_sh <= {rx_sh[14:0], sd};
                    if (rx_cnt == 16) rx_word({rx_sh[14:0], sd});
                end else begin
                    check("sd_idle", 32'(sd), 32'd0);
                end
                if (rx_cnt < 99) rx_cnt <= rx_cnt + 1;
            end
        end
    end

    initial begin
        int n;
        int viol;

        repeat (3) @(negedge clk);
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_ws", 32'(ws), 32'd0);
        check("rst_sd", 32'(sd), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_rdy", 32'(din_rdy), 32'd1);

        rst_n = 1'b1;
        en    = 1'b1;
        send(16'hA5C3);

        wait_for(1, 1'b1, 4 * CLK_DIV, "first_rise");
        n = 0;
        while (sck === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("sck_high_clks", 32'(n), 32'(CLK_DIV));
        n = 0;
        while (sck === 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("sck_low_clks", 32'(n), 32'(CLK_DIV));

        send(16'hA5C3);
        send(16'hA5C3);
        send(16'h8000);
        send(16'h7FFF);
        send(16'h0001);

        wait_for(2, 1'b1, 3 * FRAME_CLKS, "underrun");
        check("underrun_ws", 32'(ws), 32'd1);
        check("underrun_rdy", 32'(din_rdy), 32'd1);
        @(negedge clk);
        check("underrun_width", 32'(underrun), 32'd0);
        check("underrun_rdy2", 32'(din_rdy), 32'd1);

        // Line up din_vld with the next pos-32 load, one frame later
        repeat (FRAME_CLKS - 2) @(negedge clk);
        din     = 16'h1234;
        din_vld = 1'b1;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h1234);
        @(negedge clk);
        din_vld = 1'b0;
        check("simul_underrun", 32'(underrun), 32'd1);
        check("simul_held", 32'(din_rdy), 32'd0);

        send(16'hBEEF);
        wait_for(0, 1'b0, FRAME_CLKS, "frame_start");
        falls(10);
        en = 1'b0;
        wait_for(0, 1'b1, FRAME_CLKS, "stop_ws_rise");
        wait_for(0, 1'b0, FRAME_CLKS, "stop_ws_fall");
        viol = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sck !== 1'b0 || ws !== 1'b0 || sd !== 1'b0) viol++;
        end
        check("idle_quiet", 32'(viol), 32'd0);
        check("idle_drained", 32'(exp_q.size()), 32'd0);
        check("idle_rdy", 32'(din_rdy), 32'd1);

        en = 1'b1;
        send(16'hCAFE);
        send(16'h1357);
        falls(8);
        rst_n = 1'b0;
        en    = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_sck", 32'(sck), 32'd0);
        check("midrst_ws", 32'(ws), 32'd0);
        check("midrst_sd", 32'(sd), 32'd0);
        check("midrst_underrun", 32'(underrun), 32'd0);
        check("midrst_rdy", 32'(din_rdy), 32'd1);
        repeat (3) @(negedge clk);

        rst_n   = 1'b1;
        en      = 1'b1;
        din     = 16'h2468;
        din_vld = 1'b1;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                din_vld = 1'b0;
                exp_q.push_back(16'h2468);
            end
            if (sck === 1'b1) break;
        end
        // n counts the negedge after the sampling edge as 1
        check("restart_rise", 32'(n), 32'(CLK_DIV + 1));
        n = 0;
        while (exp_q.size() != 0 && n < 2 * FRAME_CLKS) begin
            @(negedge clk);
            n++;
        end
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter CLK_DIV, default 16: clk cycles per sck half-period; legal range 4..255. Default gives sck = clk/32, about 3.1 MHz at 100 MHz.
REQ-002 clk  input  1  internal clock, about 100 MHz.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  run enable for the serial clocks.
REQ-005 din  input  16  sample to transmit, two's complement.
REQ-006 din_vld  input  1  din valid.
REQ-007 din_rdy  output  1  holding register empty, can accept din.
REQ-008 sck  output  1  serial clock, registered.
REQ-009 ws  output  1  word select, registered; 0 = left slot, 1 = right slot.
REQ-010 sd  output  1  serial data, registered, MSB first.
REQ-011 underrun  output  1  one-clk pulse when a right slot starts with the holding register empty.

Function
REQ-012 FSM states: IDLE and RUN; IDLE->RUN on en=1; RUN->IDLE per REQ-020.
REQ-013 In RUN, a divider counts 0..CLK_DIV-1 and toggles sck at terminal count.
  - sck 0->1 is a rise event; sck 1->0 is a fall event.
  - First rise occurs CLK_DIV clks after RUN entry, with sck=0 on entry.
REQ-014 Frame position pos (6 bits, 0..63) advances by 1 on each fall event and wraps 63->0; pos=0 on RUN entry.
REQ-015 ws, sd and pos all update on the same clk as the fall event; ws = pos[5].
  - Left slot = pos 0..31; right slot = pos 32..63.
REQ-016 sd value by pos:
  - pos 32: 0 (one-bit I2S delay).
  - pos 33..48: bit (48-pos) of the loaded word, so MSB at pos 33 and LSB at pos 48.
  - pos 49..63 and 0..31: 0.
REQ-017 Holding register and handshake:
  - din_rdy = ~hold_full.
  - Accept on din_vld & din_rdy; the accepted word sets hold_full next clk.
  - Accepting is legal in IDLE and RUN.
REQ-018 Load on the fall event into pos 32:
  - If hold_full: the shift register takes the hold value and hold_full clears.
  - If hold empty: the shift register takes 0 and underrun pulses for that clk.
REQ-019 Simultaneous accept and underrun load (hold empty):
  - underrun still pulses and a zero word is sent.
  - The accepted word stays in hold for the next frame.
REQ-020 en=0 in RUN: the current frame completes; the fall event that would wrap pos 63->0 instead enters IDLE.
  - In IDLE: sck=0, ws=0, sd=0, pos=0, divider=0.
REQ-021 en toggling mid-frame never truncates a frame or produces an sck pulse shorter than CLK_DIV clks.
REQ-022 Latency: a word accepted in IDLE with en rising the same clk appears MSB-first at pos 33 of the first frame.
REQ-023 Output waveform: a receiver that synchronises ws/sck in 2 flops, zeroes its bit count on ws rise and captures sd on sck rises 1..16 recovers din exactly.

Reset
REQ-024 rst_n low immediately forces, regardless of current state:
  - state=IDLE; sck=0, ws=0, sd=0.
  - pos=0, divider=0, hold_full=0, shift register=0, underrun=0.
  - din_rdy=1.
REQ-025 Reset mid-frame discards any partial frame and held word; no output glitch beyond the forced zeros.
REQ-026 After release, the first rise event occurs no earlier than CLK_DIV clks after en=1 is sampled.

Structure
REQ-027 Package i2s_pkg holds:
  - SAMPLE_BITS=16, SLOT_BITS=32, FRAME_BITS=64.
  - DATA_START_POS=33, DATA_END_POS=48.
  - FSM state enum {IDLE, RUN}.
REQ-028 One sub-module, i2s_clkgen: divider plus sck register.
  - Inputs: clk, rst_n, run.
  - Outputs: sck, rise, fall strobes.
  - i2s_tx instantiates it once.
REQ-029 All outputs come directly from flops; no combinational path from din/din_vld to any output except din_rdy, which is driven from the hold_full flop.

Verification
REQ-030 CLK_DIV=16, en=1, din=16'hA5C3 held valid from reset release:
  - sd carries A5C3 MSB-first at pos 33..48 of every right slot.
  - sd=0 elsewhere; sck period = 32 clks.
REQ-031 Loopback through a 2-flop-sync rising-edge receiver model:
  - Send 16'h8000, 16'h7FFF, 16'h0001 in consecutive frames.
  - Receiver outputs the same three words, in order.
REQ-032 Hold empty at a pos-32 fall: underrun high for exactly 1 clk, a zero word is sent, din_rdy stays 1.
REQ-033 din_vld asserted on the same clk as an underrun load (din=16'h1234): underrun pulses; 1234 is sent in the next frame.
REQ-034 en dropped at pos 10:
  - Frame completes through pos 63; a word held in hold is still sent.
  - Then sck, ws and sd stay 0 for 200 clks.
REQ-035 rst_n pulsed low at pos 40 with data mid-shift: all outputs 0 and din_rdy=1 within the reset; clean frame restarts from pos 0 after release.
